// File: rtl/fc_argmax_if.sv
// fc_argmax handshake bundle: score batch in, winning class out.
// Upstream drives input_valid/d_in; the argmax block drives the rest.
interface fc_argmax_if #(
  parameter int NUM_CLASS = 10,
  parameter int IDX_W     = 4
);
  logic             input_valid;
  logic [31:0]      d_in [NUM_CLASS];
  logic             in_ready;
  logic             output_valid;
  logic [IDX_W-1:0] class_idx;
  logic [31:0]      max_val;

  modport master (
    output input_valid,
    output d_in,
    input  in_ready,
    input  output_valid,
    input  class_idx,
    input  max_val
  );

  modport slave (
    input  input_valid,
    input  d_in,
    output in_ready,
    output output_valid,
    output class_idx,
    output max_val
  );
endinterface

// File: rtl/fc_argmax.sv
// Classifier argmax: captures NUM_CLASS fp32 scores, scans one per cycle,
// returns the lowest-index maximum and its score.
module fc_argmax #(
  parameter int NUM_CLASS = 10,
  parameter int IDX_W     = 4
) (
  input logic         clk,
  input logic         rst,
  fc_argmax_if.slave  bus
);

  if (IDX_W != $clog2(NUM_CLASS)) begin : g_bad_idx_w
    $error("fc_argmax: IDX_W must equal $clog2(NUM_CLASS)");
  end
  if (NUM_CLASS < 2 || NUM_CLASS > 64) begin : g_bad_num
    $error("fc_argmax: NUM_CLASS must be in 2..64");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      best_val_q, best_val_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [31:0]      score_q [NUM_CLASS];
  logic [31:0]      score_d [NUM_CLASS];
  logic             output_valid_q, output_valid_d;
  logic [IDX_W-1:0] class_idx_q, class_idx_d;
  logic [31:0]      max_val_q, max_val_d;

  // Monotonic key: negatives flip magnitude below positives; -0 maps to +0.
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    if (x[31] && (x[30:0] != 31'd0)) begin
      return {1'b0, ~x[30:0]};
    end
    return {1'b1, x[30:0]};
  endfunction

  logic new_best;

  always_comb begin
    new_best = ord_key(score_q[cnt_q]) > ord_key(best_val_q);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    best_val_d     = best_val_q;
    best_idx_d     = best_idx_q;
    score_d        = score_q;
    output_valid_d = 1'b0;
    class_idx_d    = class_idx_q;
    max_val_d      = max_val_q;
    unique case (state_q)
      IDLE: begin
        if (bus.input_valid) begin
          score_d    = bus.d_in;
          best_val_d = bus.d_in[0];
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (new_best) begin
          best_val_d = score_q[cnt_q];
          best_idx_d = cnt_q;
        end
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        class_idx_d    = best_idx_q;
        max_val_d      = best_val_q;
        output_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      best_val_q     <= '0;
      best_idx_q     <= '0;
      output_valid_q <= 1'b0;
      class_idx_q    <= '0;
      max_val_q      <= '0;
      for (int i = 0; i < NUM_CLASS; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      best_val_q     <= best_val_d;
      best_idx_q     <= best_idx_d;
      output_valid_q <= output_valid_d;
      class_idx_q    <= class_idx_d;
      max_val_q      <= max_val_d;
      score_q        <= score_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.output_valid = output_valid_q;
  assign bus.class_idx    = class_idx_q;
  assign bus.max_val      = max_val_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: latency, compare order, ties, drop,
// reset abort and back-to-back throughput.
module tb_fc_argmax;

  localparam int N  = 10;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] vec  [N];
  logic [31:0] vecb [N];

  always #5 clk = ~clk;

  fc_argmax_if #(.NUM_CLASS(N), .IDX_W(IW)) bif ();

  fc_argmax #(.NUM_CLASS(N), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base, input int idx,
                      input logic [31:0] val);
    for (int i = 0; i < N; i++) vec[i] = base;
    vec[idx] = val;
  endtask

  // Pulse input_valid for one edge (E0) with vec; return at negedge after E0.
  task automatic capture();
    @(negedge clk);
    bif.d_in        = vec;
    bif.input_valid = 1'b1;
    @(negedge clk);
    bif.input_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] eidx,
                     input logic [31:0] eval);
    int lat;
    logic busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    capture();
    if (bif.in_ready !== 1'b0) busy_ok = 1'b0;
    for (int c = 1; c <= N + 5; c++) begin
      @(negedge clk);
      if (bif.output_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (bif.in_ready !== 1'b0) busy_ok = 1'b0;
    end
    chk({tag, "_lat"}, lat, N);
    chk({tag, "_busy"}, {31'd0, busy_ok}, 1);
    chk({tag, "_idx"}, {28'd0, bif.class_idx}, eidx);
    chk({tag, "_val"}, bif.max_val, eval);
    chk({tag, "_rdy"}, {31'd0, bif.in_ready}, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, bif.output_valid}, 0);
    chk({tag, "_hold"}, {28'd0, bif.class_idx}, eidx);
  endtask

  initial begin
    int pulses;
    bif.input_valid = 1'b0;
    for (int i = 0; i < N; i++) bif.d_in[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ov", {31'd0, bif.output_valid}, 0);
    chk("rst_idx", {28'd0, bif.class_idx}, 0);
    chk("rst_val", bif.max_val, 0);
    chk("rst_rdy", {31'd0, bif.in_ready}, 1);
    rst = 1'b0;

    // k * 1.0
    vec = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
            32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
            32'h41000000, 32'h41100000};
    run("basic", 9, 32'h41100000);

    fill(32'hBF800000, 4, 32'hBF000000);
    vec[7] = 32'h80000000;
    vec[2] = 32'h00000000;
    run("negzero", 2, 32'h00000000);

    fill(32'h3F800000, 3, 32'h40400000);
    vec[8] = 32'h40400000;
    run("tie", 3, 32'h40400000);
    vec[6] = 32'h7F800000;
    run("inf", 6, 32'h7F800000);

    fill(32'h3F800000, 0, 32'h3F800000);
    run("alleq", 0, 32'h3F800000);

    fill(32'hC0000000, 9, 32'h00000001);
    vec[5] = 32'hBF800000;
    run("denorm", 9, 32'h00000001);

    fill(32'hC0000000, 1, 32'hBF800000);
    vec[0] = 32'hC1000000;
    run("negmag", 1, 32'hBF800000);

    // Busy drop: E0 takes A; E3..E5 requests dropped; E11 takes B.
    vec = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
            32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
            32'h41000000, 32'h41100000};
    for (int i = 0; i < N; i++) vecb[i] = 32'h3F800000;
    vecb[2] = 32'h42000000;
    capture();
    pulses = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (bif.output_valid === 1'b1) begin
        pulses++;
        if (c == 10) begin
          chk("drop_a_idx", {28'd0, bif.class_idx}, 9);
          chk("drop_a_val", bif.max_val, 32'h41100000);
        end else if (c == 21) begin
          chk("drop_b_idx", {28'd0, bif.class_idx}, 2);
          chk("drop_b_val", bif.max_val, 32'h42000000);
        end else begin
          chk("drop_spurious", c, 0);
        end
      end
      if (c == 15) chk("drop_hold", bif.max_val, 32'h41100000);
      bif.d_in        = vecb;
      bif.input_valid = ((c >= 2) && (c <= 4)) || (c == 10);
    end
    bif.input_valid = 1'b0;
    chk("drop_pulses", pulses, 2);

    // Reset mid-scan at E4.
    capture();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_rdy", {31'd0, bif.in_ready}, 1);
    chk("mrst_idx", {28'd0, bif.class_idx}, 0);
    chk("mrst_val", bif.max_val, 0);
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      if (bif.output_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("mrst_nopulse", pulses, 0);
    fill(32'h3F800000, 3, 32'h40400000);
    vec[8] = 32'h40400000;
    run("mrst_after", 3, 32'h40400000);

    // Back-to-back: input_valid held; captures at E0, E11, E22.
    fill(32'h3F800000, 5, 32'h40A00000);
    @(negedge clk);
    bif.d_in        = vec;
    bif.input_valid = 1'b1;
    pulses = 0;
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      if (bif.output_valid === 1'b1) begin
        pulses++;
        if (c == 10) begin
          chk("b2b_0", {28'd0, bif.class_idx}, 5);
        end else if (c == 21) begin
          chk("b2b_1", {28'd0, bif.class_idx}, 1);
        end else if (c == 32) begin
          chk("b2b_2", {28'd0, bif.class_idx}, 8);
          chk("b2b_2v", bif.max_val, 32'h41000000);
        end else begin
          chk("b2b_spurious", c, 0);
        end
      end
      if (c == 0) begin
        fill(32'h3F800000, 1, 32'h40000000);
        bif.d_in = vec;
      end else if (c == 11) begin
        fill(32'h3F800000, 8, 32'h41000000);
        bif.d_in = vec;
      end else if (c == 22) begin
        bif.input_valid = 1'b0;
      end
    end
    chk("b2b_pulses", pulses, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
Name: fc_argmax

Overview:
- Classifier output stage; sits directly downstream of the per-class FC score units.
- Each per-class unit produces one IEEE-754 single-precision score with a one-cycle valid pulse. This block takes all NUM_CLASS scores together on one input_valid pulse.
- It scans the scores sequentially, one comparison per cycle, and returns the winning class index and its score.

Parameters:
- NUM_CLASS, 10, number of class scores; legal range 2..64.
- IDX_W, 4, width of class_idx; must equal $clog2(NUM_CLASS). An elaboration-time assertion checks this.

Ports:
- clk  input  1  Rising-edge clock; the only clock.
- rst  input  1  Synchronous, active-high reset.
- input_valid  input  1  Scores on d_in are valid this cycle. Sampled only when in_ready=1.
- d_in  input  32 x [NUM_CLASS-1:0] (unpacked)  Class scores, fp32; index = class number.
- in_ready  output  1  High when state=IDLE (combinational from state).
- output_valid  output  1  One-cycle pulse marking a new result.
- class_idx  output  IDX_W  Index of the maximum score.
- max_val  output  32  fp32 value of the maximum score.

Behaviour:
- Reset: while rst=1 at a clock edge:
  - state <- IDLE; output_valid <- 0; class_idx <- 0; max_val <- 32'd0.
  - Score registers <- 0; scan counter <- 0.
  - Reset aborts any scan in progress and discards it; no output_valid is generated.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - At an edge with input_valid=1 (edge E0): capture all NUM_CLASS scores; best_val <- d_in[0]; best_idx <- 0; cnt <- 1; go to SCAN.
- SCAN:
  - in_ready=0. Each edge compares score[cnt] with best_val.
  - If score[cnt] is strictly greater: best_val <- score[cnt], best_idx <- cnt.
  - cnt increments each edge. At the edge where cnt = NUM_CLASS-1 is compared, go to DONE.
  - SCAN occupies edges E1..E(NUM_CLASS-1).
- DONE (edge E_NUM_CLASS):
  - class_idx <- best_idx; max_val <- best_val; output_valid <- 1; go to IDLE.
  - output_valid is high for exactly the one cycle following that edge, then returns to 0.
- Latency and throughput:
  - input_valid sampled at E0; output_valid is registered at edge E_NUM_CLASS (latency = NUM_CLASS clocks).
  - The earliest next capture is edge E(NUM_CLASS+1), giving one result per NUM_CLASS+1 cycles.
- input_valid while in_ready=0 is ignored (dropped, not queued). Upstream must respect in_ready.
- class_idx and max_val hold their last result until the next DONE. They stay stable while output_valid=0.
- Compare rule: total-order fp32 compare on raw bits, purely combinational, no fp unit.
  - Both positive: the larger unsigned magnitude wins.
  - Both negative: the smaller magnitude wins.
  - Positive beats negative.
  - +0 and -0 compare equal (magnitude zero ignores sign).
- Ties: a strictly-greater test means the lowest index wins; an equal later score never replaces best.
- NaN/Inf: no special handling. Patterns are ordered by the rule above, so +Inf beats any finite value, and +NaN orders above +Inf by magnitude. Upstream is not expected to produce NaN.
- Denormals: compared by bit pattern, which remains monotonic under this rule.

Test Plan:
- Basic, NUM_CLASS=10: d_in[k]=k*1.0 (k=0 -> 0x00000000, k=9 -> 0x41100000); pulse input_valid at E0 -> output_valid high exactly one cycle after E10; class_idx=9, max_val=0x41100000; in_ready low E1..E10.
- Negatives and zero sign: all scores -1.0 (0xBF800000) except d_in[4]=-0.5 (0xBF000000) and d_in[7]=-0.0 (0x80000000), d_in[2]=+0.0 -> class_idx=2 (tie of ±0, lowest index), max_val=0x00000000.
- Tie and infinity: d_in[3]=d_in[8]=0x40400000 (3.0), others 1.0 -> class_idx=3. Repeat with d_in[6]=0x7F800000 -> class_idx=6.
- Busy drop: capture at E0; assert input_valid with different scores at E3..E5 -> exactly one output_valid, result from the E0 data; second request accepted at E11 gives its own result at E21.
- Reset mid-scan: capture at E0; rst=1 at E4 -> no output_valid; class_idx=0, max_val=0, in_ready=1 after release; new capture then completes normally.
- Back-to-back: input_valid held high continuously -> captures at E0, E11, E22; output_valid pulses after E10, E21, E32 with correct per-batch indices.
